// File: rtl/sc_stream_to_bin_if.sv
// Handshake bundle for the stochastic-to-binary converter.
// SC_S2B_THRESH_EN adds the thresh/edge_flag pair.
interface sc_stream_to_bin_if #(
   parameter int CNT_W = 8
) ();

   logic             start;
   logic             s_in;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] value;
`ifdef SC_S2B_THRESH_EN
   logic [CNT_W-1:0] thresh;
   logic             edge_flag;
`endif

`ifdef SC_S2B_THRESH_EN
   modport master (
      input  start,
      input  s_in,
      input  out_ready,
      input  thresh,
      output busy,
      output out_valid,
      output value,
      output edge_flag
   );

   modport slave (
      output start,
      output s_in,
      output out_ready,
      output thresh,
      input  busy,
      input  out_valid,
      input  value,
      input  edge_flag
   );
`else
   modport master (
      input  start,
      input  s_in,
      input  out_ready,
      output busy,
      output out_valid,
      output value
   );

   modport slave (
      output start,
      output s_in,
      output out_ready,
      input  busy,
      input  out_valid,
      input  value
   );
`endif

endinterface

// File: rtl/sc_stream_to_bin.sv
// Counts ones of a stochastic bitstream over 2^CNT_W cycles after a
// SKIP-cycle flush. Optional macro SC_S2B_THRESH_EN adds edge_flag.
module sc_stream_to_bin #(
   parameter int CNT_W = 8,
   parameter int SKIP  = 2
) (
   input logic              clk,
   input logic              reset,
   sc_stream_to_bin_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      RUN,
      DONE
   } state_t;

   localparam logic [3:0] SKIP_LAST =
      4'((SKIP > 0) ? SKIP - 1 : 0);

   state_t           state;
   logic [3:0]       skip_cnt;
   logic [CNT_W-1:0] smp_cnt;
   logic [CNT_W:0]   acc;
   logic             busy_q;
   logic             valid_q;
   logic [CNT_W-1:0] value_q;
   logic [CNT_W:0]   acc_nxt;
   logic [CNT_W-1:0] sat;
   logic             begin_ok;

`ifdef SC_S2B_THRESH_EN
   logic             flag_q;
`endif

   // running sum including the bit sampled this cycle, clamped to CNT_W bits
   assign acc_nxt = acc + {{CNT_W{1'b0}}, bus.s_in};
   assign sat     = acc_nxt[CNT_W] ? '1 : acc_nxt[CNT_W-1:0];

   // a new conversion may begin from IDLE, or from DONE as the result leaves
   assign begin_ok = bus.start &&
                     ((state == IDLE) ||
                      ((state == DONE) && bus.out_ready));

   // control FSM, counters, accumulator and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         skip_cnt <= '0;
         smp_cnt  <= '0;
         acc      <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         value_q  <= '0;
`ifdef SC_S2B_THRESH_EN
         flag_q   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (begin_ok) begin
                  state    <= (SKIP == 0) ? RUN : FLUSH;
                  busy_q   <= 1'b1;
                  skip_cnt <= '0;
                  smp_cnt  <= '0;
                  acc      <= '0;
               end
            end
            FLUSH: begin
               if (skip_cnt == SKIP_LAST) begin
                  state <= RUN;
               end else begin
                  skip_cnt <= skip_cnt + 4'd1;
               end
            end
            RUN: begin
               acc     <= acc_nxt;
               smp_cnt <= smp_cnt + 1'b1;
               if (smp_cnt == '1) begin
                  state   <= DONE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b1;
                  value_q <= sat;
`ifdef SC_S2B_THRESH_EN
                  flag_q  <= (sat >= bus.thresh);
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  if (begin_ok) begin
                     state    <= (SKIP == 0) ? RUN : FLUSH;
                     busy_q   <= 1'b1;
                     skip_cnt <= '0;
                     smp_cnt  <= '0;
                     acc      <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.out_valid = valid_q;
   assign bus.value     = value_q;
`ifdef SC_S2B_THRESH_EN
   assign bus.edge_flag = flag_q;
`endif

endmodule

// File: tb/tb_sc_stream_to_bin.sv
// Bench for sc_stream_to_bin: vector table, scoreboard queue and
// hand-written sequences for hold, back-to-back and reset cases.
module tb_sc_stream_to_bin;

   localparam int CNT_W = 8;
   localparam int SKIP  = 2;
   localparam int WIN   = 1 << CNT_W;
   localparam int THR   = 64;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   sc_stream_to_bin_if #(.CNT_W(CNT_W)) bus ();

   sc_stream_to_bin #(
      .CNT_W(CNT_W),
      .SKIP (SKIP)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int pat;
      int n;
      int exp_val;
      bit exp_flag;
   } vec_t;

   typedef struct {
      logic [CNT_W-1:0] val;
      bit               flag;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, req);
      end
   endtask

   // pattern 0: zeros, 1: ones (flush too), 2: 1,0,.. (flush ones),
   // 3: first n samples one
   function automatic logic bitval(int pat, int n, int j);
      int idx;
      if (j <= SKIP) return (pat == 1 || pat == 2);
      idx = j - SKIP - 1;
      case (pat)
         1: return 1'b1;
         2: return (idx % 2 == 0);
         3: return (idx < n);
         default: return 1'b0;
      endcase
   endfunction

   task automatic push(int ev, bit ef);
      exp_t e;
      e.val  = CNT_W'(ev);
      e.flag = ef;
      sb.push_back(e);
   endtask

   task automatic begin_conv(int ev, bit ef);
      @(negedge clk);
      bus.start = 1'b1;
      push(ev, ef);
      @(posedge clk);
   endtask

   // called just after the accepting edge; ends at a negedge in DONE
   task automatic feed(int pat, int n, int pulse_at);
      bit   busy_ok = 1'b1;
      bit   ov_ok   = 1'b1;
      exp_t e;
      for (int j = 1; j <= SKIP + WIN; j++) begin
         @(negedge clk);
         bus.start     = (j == pulse_at);
         bus.out_ready = 1'b0;
         bus.s_in      = bitval(pat, n, j);
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (bus.out_valid !== 1'b0) ov_ok = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_window", 32'(busy_ok), 1);
      chk("no_early_valid", 32'(ov_ok), 1);
      chk("valid_latency", 32'(bus.out_valid), 1);
      chk("busy_low_done", 32'(bus.busy), 0);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("value", 32'(bus.value), 32'(e.val));
`ifdef SC_S2B_THRESH_EN
         chk("edge_flag", 32'(bus.edge_flag), 32'(e.flag));
`endif
      end
   endtask

   task automatic accept();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("valid_drop", 32'(bus.out_valid), 0);
   endtask

   initial begin
      logic [CNT_W-1:0] v0;
      bit               hold_ok;

      vecs[0] = '{0, 0,   0,   0};
      vecs[1] = '{1, 0,   255, 1};
      vecs[2] = '{2, 0,   128, 1};
      vecs[3] = '{3, 64,  64,  1};
      vecs[4] = '{3, 63,  63,  0};
      vecs[5] = '{3, 1,   1,   0};
      vecs[6] = '{3, 255, 255, 1};

      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.s_in      = 1'b0;
      bus.out_ready = 1'b0;
`ifdef SC_S2B_THRESH_EN
      bus.thresh    = CNT_W'(THR);
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 0);
      chk("reset_valid", 32'(bus.out_valid), 0);
      chk("reset_value", 32'(bus.value), 0);
`ifdef SC_S2B_THRESH_EN
      chk("reset_flag", 32'(bus.edge_flag), 0);
`endif
      reset = 1'b1;

      foreach (vecs[i]) begin
         begin_conv(vecs[i].exp_val, vecs[i].exp_flag);
         feed(vecs[i].pat, vecs[i].n, 0);
         accept();
         chk("value_hold_idle", 32'(bus.value), 32'(vecs[i].exp_val));
      end

      // start pulsed mid-RUN, then ready withheld for 10 cycles
      begin_conv(200, 1);
      feed(3, 200, 50);
      v0      = bus.value;
      hold_ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.value !== v0) hold_ok = 1'b0;
      end
      chk("hold_stable", 32'(hold_ok), 1);
      chk("hold_value", 32'(v0), 200);

      // back-to-back: start with ready in DONE
      bus.start     = 1'b1;
      bus.out_ready = 1'b1;
      push(128, 1);
      @(posedge clk);
      #1;
      chk("b2b_busy", 32'(bus.busy), 1);
      chk("b2b_valid", 32'(bus.out_valid), 0);
      feed(2, 0, 0);
      accept();

      // reset at sample 100 of RUN
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      for (int j = 1; j <= SKIP + 100; j++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.s_in  = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_value", 32'(bus.value), 0);
`ifdef SC_S2B_THRESH_EN
      chk("rst_flag", 32'(bus.edge_flag), 0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      begin_conv(37, 0);
      feed(3, 37, 0);
      accept();

      chk("scoreboard_drained", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sc_stream_to_bin.md
# sc_stream_to_bin

Downstream stochastic-to-binary converter for the stochastic edge-detection datapath. It consumes the unipolar output bitstream `s` of the edge-detector stage and counts its ones over a fixed window of 2^CNT_W clock cycles. It returns a CNT_W-bit edge-magnitude pixel value through a valid/ready handshake. A programmable flush period discards the first bits, which are invalid while the upstream sc_sub/sc_abs/sc_add registers fill after a new pixel window is applied.

## Interface

Parameters:
- `CNT_W`, default 8: window length is 2^CNT_W bits; output width is CNT_W.
- `SKIP`, default 2: number of leading bitstream cycles discarded (pipeline flush); legal range 0..15.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Asserting (0) immediately forces reset state; deassertion is synchronous to `clk` at the system level.
- `start`, input, 1: single-cycle request to begin a conversion.
- `s_in`, input, 1: stochastic bitstream from the edge detector.
- `busy`, output, 1: high in FLUSH and RUN.
- `out_valid`, output, 1: high in DONE; `value` is stable while high.
- `out_ready`, input, 1: consumer accepts `value` when `out_valid && out_ready`.
- `value`, output, CNT_W: converted magnitude.
- `thresh`, input, CNT_W: present only with `SC_S2B_THRESH_EN`.
- `edge_flag`, output, 1: present only with `SC_S2B_THRESH_EN`.

## Operation

- **State machine:** IDLE, FLUSH, RUN, DONE.
- **IDLE:**
  - `start=1` goes to FLUSH with the skip counter cleared; if SKIP=0, it goes directly to RUN.
  - The accumulator is cleared on acceptance.
- **FLUSH:** `s_in` is ignored. After SKIP cycles the block goes to RUN.
- **RUN:**
  - Each cycle, `s_in` is added to a CNT_W+1-bit accumulator, and a CNT_W-bit sample counter increments.
  - When the counter wraps after its 2^CNT_W-th sample, the block goes to DONE.
- **DONE:**
  - `value` = min(accumulator, 2^CNT_W − 1), so an all-ones stream saturates rather than wraps. `value` is registered on entry to DONE.
  - `out_valid=1` until the handshake completes.
  - On `out_ready=1`:
    - If `start=1` in the same cycle, go to FLUSH (or RUN) with the accumulator cleared. This gives back-to-back conversions.
    - Otherwise go to IDLE.
- `start` in FLUSH or RUN is ignored; there is no queueing or restart.
- `start` in DONE without `out_ready` is ignored.
- `value` holds its last converted result in IDLE. It changes only on entry to DONE.
- **Reset, asynchronous, any state:**
  - The state goes to IDLE, and all counters and the accumulator clear.
  - `value=0`, `out_valid=0`, `busy=0`, `edge_flag=0`.
  - A conversion in progress is abandoned, with no partial output.

## Timing

- **Reset values:** `busy=0`, `out_valid=0`, `value=0`, `edge_flag=0`.
- Let start be accepted at rising edge k:
  - FLUSH spans cycles k..k+SKIP−1.
  - RUN spans cycles k+SKIP..k+SKIP+2^CNT_W−1, sampling `s_in` at each of those edges.
  - `out_valid` rises after edge k+SKIP+2^CNT_W.
- Latency from start to `out_valid` is SKIP + 2^CNT_W cycles. With the defaults this is 258.
- `busy` is high from the cycle after acceptance until the cycle before `out_valid` rises.
- In the back-to-back case, `out_valid` falls the cycle after the handshake and `busy` rises in that same cycle.
- Throughput is one conversion per SKIP + 2^CNT_W + 1 cycles with `out_ready` tied high and `start` re-asserted in DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- `SC_S2B_THRESH_EN` defined:
  - Adds the `thresh` input and `edge_flag` output.
  - `edge_flag` is registered together with `value` on entry to DONE: 1 when the saturated value ≥ `thresh`.
  - `thresh` is sampled at that same edge.
  - `edge_flag` holds with `value` and clears on reset.
- Not defined: neither port exists and there is no comparator logic. Behaviour is otherwise identical.

## Test plan

- Defaults, `s_in`=0 for the whole window → `value`=0, with `out_valid` rising exactly 258 cycles after start.
- `s_in`=1 constantly, including during FLUSH → accumulator reaches 256 and `value` saturates to 255.
- `s_in` alternating 1,0 during RUN, with FLUSH bits forced to 1 → `value`=128, proving the flushed bits are discarded.
- `start` pulsed mid-RUN, then `out_ready` held low for 10 cycles in DONE → the conversion is unaffected, and `value`/`out_valid` stay stable until ready. `start` together with ready then gives `busy`=1 on the next cycle.
- `reset` asserted at sample 100 of RUN → all outputs go to 0 immediately. The next start produces a fresh, correct count.
- With `SC_S2B_THRESH_EN`, `thresh`=64 → `edge_flag`=1 for a stream of 64 ones and `edge_flag`=0 for 63 ones.
